// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline forwarding, hazard stall/flush and data-memory wait control (optional STALL_CNT_EN stall counter)
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_rsD,
  input  logic [4:0] i_rtD,
  input  logic [4:0] i_rsE,
  input  logic [4:0] i_rtE,
  input  logic [4:0] i_writeregE,
  input  logic [4:0] i_writeregM,
  input  logic [4:0] i_writeregW,
  input  logic       i_regwriteE,
  input  logic       i_regwriteM,
  input  logic       i_regwriteW,
  input  logic       i_memtoregE,
  input  logic       i_memtoregM,
  input  logic       i_branchD,
  input  logic       i_memreqM,
  input  logic       i_memreadyM,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_stallE,
  output logic       o_stallM,
  output logic       o_flushE,
  output logic       o_flushW,
  output logic [1:0] o_forwardAE,
  output logic [1:0] o_forwardBE,
  output logic       o_forwardAD,
  output logic       o_forwardBD,
  output logic       o_memerr
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] o_stallcnt
`endif
);

  // The transition to ERROR happens on the MEM_TIMEOUT-th consecutive MEMWAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_MEMWAIT, S_ERROR} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_memerr;
  logic       w_memstall;
  logic       w_lwstall;
  logic       w_branchstall;
  logic       w_hazard;

  // E-stage operand source: M result beats W result; register 0 never forwards.
  function automatic logic [1:0] fwd_e(input logic [4:0] src, input logic [4:0] wr_m,
                                       input logic rw_m, input logic [4:0] wr_w,
                                       input logic rw_w);
    if (src != 5'd0 && rw_m && src == wr_m)      return 2'b10;
    else if (src != 5'd0 && rw_w && src == wr_w) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Memory-wait state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_RUN;
    else         r_state <= w_next;
  end

  // Wait counter: cleared on MEMWAIT entry, counts MEMWAIT cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                      r_wait_cnt <= 8'd0;
    else if (r_state == S_RUN && w_next == S_MEMWAIT) r_wait_cnt <= 8'd0;
    else if (r_state == S_MEMWAIT)                    r_wait_cnt <= r_wait_cnt + 8'd1;
  end

  // Sticky error flag, set together with ERROR entry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                r_memerr <= 1'b0;
    else if (w_next == S_ERROR) r_memerr <= 1'b1;
  end

  // Next state and memory stall; ready always wins over the timeout.
  always_comb begin
    w_next     = r_state;
    w_memstall = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_memreqM && !i_memreadyM) begin
          w_next     = S_MEMWAIT;
          w_memstall = 1'b1;
        end
      end
      S_MEMWAIT: begin
        w_memstall = !i_memreadyM;
        if (i_memreadyM)                     w_next = S_RUN;
        else if (r_wait_cnt == TIMEOUT_LAST) w_next = S_ERROR;
      end
      S_ERROR: begin
        w_memstall = 1'b1;
      end
      default: begin
        w_next = S_RUN;
      end
    endcase
  end

  // Load-use and branch-compare data hazards.
  always_comb begin
    w_lwstall     = i_memtoregE && (i_rtE == i_rsD || i_rtE == i_rtD);
    w_branchstall = i_branchD &&
                    ((i_regwriteE && (i_writeregE == i_rsD || i_writeregE == i_rtD)) ||
                     (i_memtoregM && (i_writeregM == i_rsD || i_writeregM == i_rtD)));
    w_hazard      = w_lwstall || w_branchstall;
  end

  // Stall/flush/forward outputs; a memory stall freezes everything and drains W.
  always_comb begin
    o_stallF    = 1'b0;
    o_stallD    = 1'b0;
    o_stallE    = 1'b0;
    o_stallM    = 1'b0;
    o_flushE    = 1'b0;
    o_flushW    = 1'b0;
    o_forwardAE = 2'b00;
    o_forwardBE = 2'b00;
    o_forwardAD = 1'b0;
    o_forwardBD = 1'b0;
    if (!i_reset) begin
      if (w_memstall) begin
        o_stallF = 1'b1;
        o_stallD = 1'b1;
        o_stallE = 1'b1;
        o_stallM = 1'b1;
        o_flushW = 1'b1;
      end else begin
        o_stallF = w_hazard;
        o_stallD = w_hazard;
        o_flushE = w_hazard;
      end
      o_forwardAE = fwd_e(i_rsE, i_writeregM, i_regwriteM, i_writeregW, i_regwriteW);
      o_forwardBE = fwd_e(i_rtE, i_writeregM, i_regwriteM, i_writeregW, i_regwriteW);
      o_forwardAD = (i_rsD != 5'd0) && i_regwriteM && (i_rsD == i_writeregM);
      o_forwardBD = (i_rtD != 5'd0) && i_regwriteM && (i_rtD == i_writeregM);
    end
  end

  assign o_memerr = r_memerr;

`ifdef STALL_CNT_EN
  logic [31:0] r_stallcnt;

  // Saturating count of fetch-stalled cycles.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                              r_stallcnt <= 32'd0;
    else if (o_stallF && r_stallcnt != '1)    r_stallcnt <= r_stallcnt + 32'd1;
  end

  assign o_stallcnt = r_stallcnt;
`endif

endmodule
